// File: rtl/muladd_m.sv
// Sequential unsigned multiply-add p = a*b + c, one multiplier bit per clock.
// Optional `ovf` output (high half of p non-zero) is compiled in with MULADD_OVF_EN.
module muladd_m #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            ready,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [DW-1:0]   c,
    output logic [2*DW-1:0] p
`ifdef MULADD_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam int CW = $clog2(DW);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2*DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0]   mplier_q, mplier_d;
    logic [2*DW-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*DW-1:0] p_q, p_d;
    logic [2*DW-1:0] sum;
`ifdef MULADD_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    // Accumulator after folding in the current multiplier bit
    assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
`ifdef MULADD_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{DW{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = {{DW{1'b0}}, c};
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    p_d     = sum;
`ifdef MULADD_OVF_EN
                    ovf_d   = |sum[2*DW-1:DW];
`endif
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
`ifdef MULADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
`ifdef MULADD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign ready = (state_q == IDLE);
    assign p     = p_q;
`ifdef MULADD_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_muladd_m.sv
// Randomized scoreboard bench for muladd_m: driver queues a*b+c, a negedge monitor
// pops on each completion and also checks latency, result hold and reset values.
module tb_muladd_m;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            ready;
    logic [DW-1:0]   a_i, b_i, c_i;
    logic [2*DW-1:0] p;
`ifdef MULADD_OVF_EN
    logic            ovf;
`endif

    muladd_m #(.DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ready (ready),
        .a     (a_i),
        .b     (b_i),
        .c     (c_i),
        .p     (p)
`ifdef MULADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*DW-1:0] exp_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*DW-1:0] model(input longint a, input longint b, input longint c);
        return (2*DW)'(a * b + c);
    endfunction

    // Monitor
    logic            ready_prev  = 1'b1;
    logic            rst_pending = 1'b0;
    logic [2*DW-1:0] last_p      = '0;
    int              low_cnt     = 0;

    always @(negedge clk) begin
        logic [2*DW-1:0] e;
        if (rst_pending) begin
            chk("reset_ready", longint'(ready), 1);
            chk("reset_p", longint'(p), 0);
`ifdef MULADD_OVF_EN
            chk("reset_ovf", longint'(ovf), 0);
`endif
            last_p  = '0;
            low_cnt = 0;
        end else if (ready && !ready_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_completion", longint'(p), -1);
            end else begin
                e = exp_q.pop_front();
                chk("result_p", longint'(p), longint'(e));
                chk("latency", low_cnt, DW);
`ifdef MULADD_OVF_EN
                chk("result_ovf", longint'(ovf), longint'(e[2*DW-1:DW] != 0));
`endif
                last_p = e;
            end
            low_cnt = 0;
        end else begin
            chk("p_hold", longint'(p), longint'(last_p));
            if (!ready) low_cnt++;
        end
        ready_prev  = ready;
        rst_pending = rst;
    end

    // Driver
    task automatic wait_ready();
        int i = 0;
        while (!ready && i < 200) begin
            @(posedge clk); #1;
            i++;
        end
        chk("ready_wait", longint'(ready), 1);
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        wait_ready();
        a_i = a; b_i = b; c_i = c;
        start = 1'b1;
        exp_q.push_back(model(a, b, c));
        @(posedge clk); #1;
        start = 1'b0;
        a_i = DW'($urandom); b_i = DW'($urandom); c_i = DW'($urandom);
    endtask

    initial begin
        int cyc, comps, last_cyc, n, d;
        rst = 1'b1; start = 1'b1;
        a_i = 8'd9; b_i = 8'd9; c_i = 8'd9;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_op(8'd13, 8'd19, 8'd5);
        run_op(8'd255, 8'd255, 8'd255);
        run_op(8'd0, 8'd255, 8'd7);
        run_op(8'd255, 8'd0, 8'd0);
        run_op(8'd1, 8'd1, 8'd0);

        for (int i = 0; i < 40; i++)
            run_op(DW'($urandom), DW'($urandom), DW'($urandom));

        // Divider round trip: a=q, b=d, c=r must rebuild n
        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(1, 255);
            d = $urandom_range(1, 255);
            run_op(DW'(n / d), DW'(d), DW'(n % d));
        end
        run_op(8'd1, 8'd255, 8'd0);
        run_op(8'd0, 8'd255, 8'd254);

        // start pulsed and operands changed while busy: ignored
        run_op(8'd3, 8'd4, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        a_i = 8'd99; b_i = 8'd99; c_i = 8'd99; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        // start held high: three back-to-back operations every DW+1 clocks
        wait_ready();
        a_i = 8'd17; b_i = 8'd11; c_i = 8'd3; start = 1'b1;
        repeat (3) exp_q.push_back(model(17, 11, 3));
        cyc = 0; comps = 0; last_cyc = 0;
        while (comps < 3 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (ready) begin
                comps++;
                if (comps > 1) chk("held_cadence", cyc - last_cyc, DW + 1);
                last_cyc = cyc;
            end
        end
        start = 1'b0;
        chk("held_count", comps, 3);

        // Reset mid-operation discards the result
        run_op(8'd200, 8'd200, 8'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        chk("abort_ready", longint'(ready), 1);
        chk("abort_p", longint'(p), 0);
        run_op(8'd2, 8'd3, 8'd1);

        cyc = 0;
        while ((exp_q.size() != 0 || !ready) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (DW + 3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        chk("final_p", longint'(p), 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muladd_m.md
# muladd_m

Sequential unsigned multiply-add: computes p = a*b + c with a shift-add datapath, one multiplier bit per clock, under the same start/ready handshake as `div_m`. It is the inverse of `div_m`. Feeding a quotient, divisor and remainder back in (a=q, b=d, c=r) reconstructs the dividend. It is used for result checking and for rescaling paths next to the divider.

## Interface
- `DW`, 8, operand width in bits; legal range 2..32.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only while `ready`=1.
- `ready`  out  1  idle/result-valid flag.
- `a`  in  DW  multiplicand, unsigned.
- `b`  in  DW  multiplier, unsigned.
- `c`  in  DW  addend, unsigned.
- `p`  out  2*DW  result a*b + c, unsigned.
- `ovf`  out  1  present only with `MULADD_OVF_EN`; result does not fit in DW bits.

## Operation
- The FSM has two states: IDLE (`ready`=1) and BUSY (`ready`=0).
- **IDLE, `start`=1 at an edge:**
  - Capture `a`, `b`, `c` into internal registers.
  - Accumulator = zero-extended `c`; bit counter = 0; go to BUSY.
  - `p` keeps its old value until completion.
- **BUSY, each edge:**
  - If the current multiplier bit (LSB first) is 1, add the shifted multiplicand to the 2*DW accumulator.
  - Shift the multiplicand left and the multiplier right; increment the counter.
- **Completion:** on the edge that processes bit DW-1:
  - `p` gets the final accumulator value; `ovf` updates if compiled in.
  - `ready` goes to 1; state returns to IDLE.
- **Width rule:** the maximum result is (2^DW-1)^2 + (2^DW-1) = 2^(2DW) - 2^DW, so 2*DW bits never overflow. No truncation or saturation anywhere.
- **Fixed latency:** no early termination. Latency is the same for a=0, b=0 or any operand values.
- **`start` while BUSY:** ignored, no queuing.
- **Operand changes after capture:** ignored.
- **`start` held high:** a new operation launches on the first IDLE edge, i.e. the edge immediately after `ready` rises.
- **`p` hold:** `p` holds until the next completion, not the next start.
- **Reset at any time, including mid-operation:**
  - State → IDLE, `ready`=1, `p`=0, `ovf`=0; counter and internal registers cleared.
  - The aborted result is discarded.
  - Reset has priority over `start` on the same edge.

## Timing
- Reset values: `ready`=1, `p`=0, `ovf`=0.
- `start` sampled high at edge k: `ready`=0 from edge k until edge k+DW.
- At edge k+DW: `ready`=1 and `p` is valid. Latency is DW clocks.
- Throughput: one operation per DW+1 clocks when `start` is pulsed on the cycle after `ready` rises. With `start` held high, the cadence is one operation per DW+1 clocks as well.
- The `div_m`-style handshake is directly compatible. Pulse `start` one cycle, `wait(ready)`, then read `p` on the next edge.

## Configuration
- **`MULADD_OVF_EN` defined:**
  - Port `ovf` exists.
  - `ovf` is a register loaded at completion with (`p[2*DW-1:DW]` != 0); it flags results that do not fit a DW-bit dividend.
  - It holds with `p` and clears on reset.
- **`MULADD_OVF_EN` undefined:** port `ovf` and its register are absent. All other behaviour is identical.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `start`=1 → `ready`=1, `p`=0, `ovf`=0; no operation launched.
- **Basic, DW=8:** a=13, b=19, c=5, `start` pulsed at edge k → `ready`=0 for edges k..k+7; at edge k+8 `ready`=1, `p`=252, `ovf`=0.
- **Extremes, DW=8:**
  - a=255, b=255, c=255 → `p`=65280, `ovf`=1.
  - a=0, b=255, c=7 → `p`=7, still 8 cycles of latency.
- **Round trip with `div_m`, DW=8:**
  - Sweep all n in 1..255 and d in 1..255.
  - Drive a=q, b=d, c=r from `div_m` → `p`==n and `ovf`=0 for every pair.
  - Stop with "Error" on the first mismatch.
- **Protocol:**
  - Start a=3, b=4, c=0; then change a/b/c and pulse `start` at cycle 3 of BUSY → completes with `p`=12 at edge k+8; no second operation.
  - `start` held high → back-to-back results every 9 cycles.
- **Reset mid-operation:** start a=200, b=200, c=1; assert `rst` at cycle 4 → `ready`=1 and `p`=0 the next edge. A fresh start a=2, b=3, c=1 then yields `p`=7 after 8 cycles.
